rr_arbiter4: RTL and testbench

- Round-robin arbiter and sequencer that shares one 16-bit resource port (e.g. a RAM or peripheral write/read channel) among four requesters a, b, c, d.
- Picks one requester, holds the grant across a request/accept/response transaction, then routes the response strobe back to the winner only.
- Routes strobes through the existing 4-way demultiplexor; includes a response-timeout counter so a dead resource cannot hang the bus.

---
 rtl/rr_arbiter4_pkg.sv | 23 ++
 rtl/rr_arbiter4_if.sv | 28 ++
 rtl/demux4.sv | 14 +
 rtl/rr_pick4.sv | 28 ++
 rtl/rr_arbiter4.sv | 127 ++++++++++++
 tb/tb_rr_arbiter4.sv | 239 +++++++++++++++++++++++
 6 files changed

// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin resource arbiter:
// FSM encoding, default data width, requester indices and a one-hot helper.
package rr_arbiter4_pkg;

   localparam int DW_DEF = 16;
   localparam int NREQ   = 4;

   localparam logic [1:0] REQ_A = 2'd0;
   localparam logic [1:0] REQ_B = 2'd1;
   localparam logic [1:0] REQ_C = 2'd2;
   localparam logic [1:0] REQ_D = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Bundle of requester-side and resource-side signals around the arbiter.
// slave is the arbiter's view, master is the view of whatever drives it.
interface rr_arbiter4_if #(parameter int DW = 16);

   logic [3:0]      req;
   logic [4*DW-1:0] req_data;
   logic [3:0]      gnt;
   logic            mem_valid;
   logic            mem_ready;
   logic [DW-1:0]   mem_data;
   logic [1:0]      mem_id;
   logic            rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic [3:0]      done;
   logic [3:0]      err;
   logic [DW-1:0]   rsp_out;

   modport slave (
      input  req, req_data, mem_ready, rsp_valid, rsp_data,
      output gnt, mem_valid, mem_data, mem_id, done, err, rsp_out
   );

   modport master (
      output req, req_data, mem_ready, rsp_valid, rsp_data,
      input  gnt, mem_valid, mem_data, mem_id, done, err, rsp_out
   );

endinterface

// File: rtl/demux4.sv
// Four-way single-bit demultiplexor: routes in_i to out_o[sel_i], others 0.
module demux4 (
   input  logic       in_i,
   input  logic [1:0] sel_i,
   output logic [3:0] out_o
);

   always_comb begin
      // NOTE: every output gets a default before the selective write, so no latch is inferred.
      out_o        = '0;
      out_o[sel_i] = in_i;
   end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request searching from ptr_i
// upwards, wrapping modulo 4.
module rr_pick4 (
   input  logic [3:0] req_i,
   input  logic [1:0] ptr_i,
   output logic       any_o,
   output logic [1:0] winner_o
);

   logic       found;
   logic [1:0] idx;

   always_comb begin
      winner_o = ptr_i;
      found    = 1'b0;
      idx      = ptr_i;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_i + 2'(i);
         if (!found && req_i[idx]) begin
            winner_o = idx;
            found    = 1'b1;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter sharing one request/response resource port among four
// requesters, with per-owner done/err pulses and a response timeout.
module rr_arbiter4
   import rr_arbiter4_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   rr_arbiter4_if.slave   arb_if
);

   localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_e        state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [1:0]    id_q, id_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] rsp_out_q, rsp_out_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [3:0]    done_q, done_d;
   logic [3:0]    err_q, err_d;
   logic          complete;
   logic          timeout;
   logic          pick_any;
   logic [1:0]    pick_id;

   rr_pick4 u_pick (
      .req_i    (arb_if.req),
      .ptr_i    (ptr_q),
      .any_o    (pick_any),
      .winner_o (pick_id)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      cnt_d     = cnt_q;
      rsp_out_d = rsp_out_q;
      complete  = 1'b0;
      timeout   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               id_d    = pick_id;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // Acceptance takes priority over the owner dropping its request.
            if (arb_if.mem_ready) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end else if (!arb_if.req[id_q]) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (arb_if.rsp_valid) begin
               complete  = 1'b1;
               rsp_out_d = arb_if.rsp_data;
               ptr_d     = id_q + 2'd1;
               state_d   = ST_IDLE;
            end else if (TIMEOUT != 0) begin
               if (cnt_q == CNT_LAST) begin
                  timeout = 1'b1;
                  ptr_d   = id_q + 2'd1;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      gnt_d = (state_d != ST_IDLE) ? onehot4(id_d) : '0;
   end

   demux4 u_done_demux (
      .in_i  (complete),
      .sel_i (id_q),
      .out_o (done_d)
   );

   demux4 u_err_demux (
      .in_i  (timeout),
      .sel_i (id_q),
      .out_o (err_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= REQ_A;
         id_q      <= REQ_A;
         cnt_q     <= '0;
         rsp_out_q <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         cnt_q     <= cnt_d;
         rsp_out_q <= rsp_out_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign arb_if.gnt       = gnt_q;
   assign arb_if.mem_valid = (state_q == ST_GRANT);
   assign arb_if.mem_id    = id_q;
   assign arb_if.mem_data  = arb_if.req_data[id_q*DW +: DW];
   assign arb_if.done      = done_q;
   assign arb_if.err       = err_q;
   assign arb_if.rsp_out   = rsp_out_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_rr_arbiter4;

   localparam int DW = 16;
   localparam int TO = 15;

   typedef enum {EV_ACC, EV_DONE, EV_ERR} ev_kind_e;
   typedef struct {
      ev_kind_e   kind;
      logic [1:0] id;
      logic [15:0] data;
   } ev_t;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   int   m_ptr;
   ev_t  exp_q[$];

   rr_arbiter4_if #(.DW(DW)) bus ();

   rr_arbiter4 #(.DW(DW), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] oh(input logic [1:0] i);
      logic [3:0] v;
      v = 4'b0001;
      return v << i;
   endfunction

   // Model: first requester at or after the round-robin pointer, modulo 4.
   function automatic logic [1:0] model_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return 2'((p + k) % 4);
      return 2'd0;
   endfunction

   function automatic logic [63:0] rand_data();
      return {$urandom(), $urandom()};
   endfunction

   // Monitor: pops one expectation for each acceptance or completion pulse.
   always @(negedge clk) begin
      ev_t e;
      if (rst_n) begin
         if (bus.mem_valid && bus.mem_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_accept", 64'(bus.mem_id), 64'hFFFF);
            end else begin
               e = exp_q.pop_front();
               check("acc_order", 64'(e.kind == EV_ACC), 64'd1);
               check("acc_id", 64'(bus.mem_id), 64'(e.id));
               check("acc_data", 64'(bus.mem_data), 64'(e.data));
               check("acc_gnt", 64'(bus.gnt), 64'(oh(e.id)));
            end
         end
         if (bus.done != 0 || bus.err != 0) begin
            check("done_err_excl", 64'(bus.done & bus.err), 64'd0);
            if (exp_q.size() == 0) begin
               check("spurious_pulse", 64'({bus.done, bus.err}), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("pulse_done", 64'(bus.done), (e.kind == EV_DONE) ? 64'(oh(e.id)) : 64'd0);
               check("pulse_err", 64'(bus.err), (e.kind == EV_ERR) ? 64'(oh(e.id)) : 64'd0);
               if (e.kind == EV_DONE) check("rsp_out", 64'(bus.rsp_out), 64'(e.data));
            end
         end
      end
   end

   task automatic do_txn(input logic [3:0] reqv, input logic [63:0] rdata, input int ready_dly,
                         input bit tmo, input int rsp_dly, input logic [15:0] rword);
      logic [1:0]  w;
      logic [15:0] wdata;
      int          n;
      w     = model_pick(reqv, m_ptr);
      wdata = rdata[int'(w)*16 +: 16];
      exp_q.push_back('{EV_ACC, w, wdata});
      if (tmo) exp_q.push_back('{EV_ERR, w, 16'h0});
      else     exp_q.push_back('{EV_DONE, w, rword});

      bus.req      = reqv;
      bus.req_data = rdata;
      step();
      n = 0;
      while (!bus.mem_valid && n < 8) begin
         step();
         n++;
      end
      check("grant_latency", 64'(n), 64'd0);
      check("grant_gnt", 64'(bus.gnt), 64'(oh(w)));

      for (int i = 0; i < ready_dly; i++) begin
         bus.rsp_valid = 1'($urandom_range(0, 1));
         step();
         check("hold_valid", 64'(bus.mem_valid), 64'd1);
         check("hold_id", 64'(bus.mem_id), 64'(w));
         check("hold_data", 64'(bus.mem_data), 64'(wdata));
      end
      bus.rsp_valid = 1'b0;
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      bus.req       = 4'b0000;

      if (tmo) begin
         n = 0;
         while (bus.err == 0 && n < TO + 10) begin
            check("tmo_no_done", 64'(bus.done), 64'd0);
            step();
            n++;
         end
         check("tmo_cycles", 64'(n), 64'(TO));
         check("tmo_err", 64'(bus.err), 64'(oh(w)));
      end else begin
         repeat (rsp_dly) step();
         bus.rsp_valid = 1'b1;
         bus.rsp_data  = rword;
         step();
         bus.rsp_valid = 1'b0;
         check("done_now", 64'(bus.done), 64'(oh(w)));
      end
      m_ptr = (int'(w) + 1) % 4;
   endtask

   task automatic abandon(input logic [3:0] reqv);
      logic [1:0] w;
      w            = model_pick(reqv, m_ptr);
      bus.req      = reqv;
      bus.req_data = rand_data();
      step();
      check("abn_valid", 64'(bus.mem_valid), 64'd1);
      check("abn_id", 64'(bus.mem_id), 64'(w));
      bus.req = 4'b0000;
      step();
      check("abn_dropped", 64'(bus.mem_valid), 64'd0);
      check("abn_gnt", 64'(bus.gnt), 64'd0);
      step();
      check("abn_quiet", 64'({bus.done, bus.err}), 64'd0);
   endtask

   initial begin
      tests         = 0;
      fails         = 0;
      m_ptr         = 0;
      rst_n         = 1'b0;
      bus.req       = 4'b0000;
      bus.req_data  = '0;
      bus.mem_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", 64'(bus.gnt), 64'd0);
      check("rst_valid", 64'(bus.mem_valid), 64'd0);
      check("rst_id", 64'(bus.mem_id), 64'd0);
      check("rst_pulses", 64'({bus.done, bus.err}), 64'd0);
      check("rst_rsp_out", 64'(bus.rsp_out), 64'd0);
      rst_n = 1'b1;
      step();

      // Reset in the middle of a grant drops it at once.
      bus.req = 4'b0100;
      step();
      check("pre_rst_valid", 64'(bus.mem_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_gnt", 64'(bus.gnt), 64'd0);
      check("midrst_valid", 64'(bus.mem_valid), 64'd0);
      check("midrst_pulses", 64'({bus.done, bus.err}), 64'd0);
      bus.req = 4'b0000;
      step();
      rst_n = 1'b1;
      m_ptr = 0;
      step();
      do_txn(4'b0001, rand_data(), 0, 1'b0, 1, 16'h0A0A);

      // Single request with known data, then all-request picks d.
      begin
         logic [63:0] d;
         d = rand_data();
         d[47:32] = 16'hBEEF;
         do_txn(4'b0100, d, 0, 1'b0, 2, 16'h1234);
      end
      do_txn(4'b1111, rand_data(), 0, 1'b0, 0, 16'h5555);

      repeat (5) do_txn(4'b1111, rand_data(), 0, 1'b0, 0, 16'($urandom()));

      do_txn(4'b0010, rand_data(), 5, 1'b0, 1, 16'h00FF);

      do_txn(4'b1000, rand_data(), 0, 1'b1, 0, 16'h0);
      do_txn(4'b1000, rand_data(), 0, 1'b0, TO - 1, 16'hCAFE);

      abandon(4'b0010);
      do_txn(4'b0011, rand_data(), 0, 1'b0, 0, 16'h7777);

      for (int t = 0; t < 60; t++) begin
         logic [3:0] r;
         r = 4'($urandom_range(1, 15));
         if ($urandom_range(0, 9) == 0) abandon(r);
         else do_txn(r, rand_data(), int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                     int'($urandom_range(0, TO - 1)), 16'($urandom()));
         repeat ($urandom_range(0, 2)) step();
      end

      repeat (4) step();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
